// File: rtl/secure_ram_arbiter_pkg.sv
// secure_ram_pkg: shared host tags, owner-pipe entry type and arbitration helper
package secure_ram_pkg;

    typedef enum logic {
        HOST_INSTR = 1'b0,
        HOST_DATA  = 1'b1
    } host_e;

    typedef struct packed {
        logic  vld;
        host_e host;
    } owner_t;

    localparam int RAM_LATENCY_DEFAULT = 2;
    localparam int AW_DEFAULT          = 32;
    localparam int DW_DEFAULT          = 32;

    // Data wins when it is the only requester, or when both request and instr was served last
    function automatic logic pick_data(logic instr_req, logic data_req, host_e last_grant);
        return data_req & (~instr_req | (last_grant == HOST_INSTR));
    endfunction

endpackage

// File: rtl/secure_ram_arbiter_if.sv
// secure_ram_arbiter_if: fetch, LSU and RAM buses seen from the arbiter (slave) and its environment (master)
interface secure_ram_arbiter_if #(
    parameter int AW = secure_ram_pkg::AW_DEFAULT,
    parameter int DW = secure_ram_pkg::DW_DEFAULT
);
    logic          instr_req_i;
    logic [AW-1:0] instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [DW-1:0] instr_rdata_o;

    logic          data_req_i;
    logic          data_we_i;
    logic [3:0]    data_be_i;
    logic [AW-1:0] data_addr_i;
    logic [DW-1:0] data_wdata_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [DW-1:0] data_rdata_o;

    logic          ram_req_o;
    logic          ram_we_o;
    logic [3:0]    ram_be_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic          ram_gnt_i;
    logic          ram_rvalid_i;
    logic [DW-1:0] ram_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        input  ram_gnt_i, ram_rvalid_i, ram_rdata_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        output ram_gnt_i, ram_rvalid_i, ram_rdata_i
    );

endinterface

// File: rtl/secure_ram_arbiter_owner_pipe.sv
// secure_ram_owner_pipe: fixed-depth shift register tagging each RAM cycle with its owning host
module secure_ram_owner_pipe
    import secure_ram_pkg::*;
#(
    parameter int DEPTH = RAM_LATENCY_DEFAULT
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  owner_t head_i,
    output owner_t tail_o
);

    owner_t pipe_q [DEPTH];

    // Every tag moves one stage per cycle; idle cycles load an invalid tag so slots stay aligned
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= head_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/secure_ram_arbiter.sv
// secure_ram_arbiter: round-robin merge of fetch and LSU onto one secure RAM with zero-forced idle data paths
module secure_ram_arbiter
    import secure_ram_pkg::*;
#(
    parameter int RAM_LATENCY = RAM_LATENCY_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    secure_ram_arbiter_if.slave   bus,
    output logic                  proto_err_o
);

    host_e  last_q, last_d, winner;
    owner_t head, tail;
    logic   req, sel_data, accept, resp, err_q, err_d;

    // Pick the winner and drive the RAM bus only from it; unused fields stay at 0
    always_comb begin
        req              = bus.instr_req_i | bus.data_req_i;
        sel_data         = pick_data(bus.instr_req_i, bus.data_req_i, last_q);
        winner           = sel_data ? HOST_DATA : HOST_INSTR;
        accept           = req & bus.ram_gnt_i;
        last_d           = accept ? winner : last_q;
        head             = '{vld: accept, host: winner};
        bus.ram_req_o    = req;
        bus.ram_we_o     = sel_data & bus.data_we_i;
        bus.ram_be_o     = sel_data ? bus.data_be_i : (bus.instr_req_i ? 4'hF : 4'h0);
        bus.ram_addr_o   = sel_data ? bus.data_addr_i : (bus.instr_req_i ? bus.instr_addr_i : '0);
        bus.ram_wdata_o  = sel_data ? bus.data_wdata_i : '0;
        bus.instr_gnt_o  = ~sel_data & bus.instr_req_i & bus.ram_gnt_i;
        bus.data_gnt_o   = sel_data & bus.ram_gnt_i;
    end

    secure_ram_owner_pipe #(.DEPTH(RAM_LATENCY)) u_owner_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .head_i (head),
        .tail_o (tail)
    );

    // Route a response only to the tagged host; any tag/rvalid disagreement is dropped and flagged
    always_comb begin
        resp               = tail.vld & bus.ram_rvalid_i;
        err_d              = err_q | (tail.vld != bus.ram_rvalid_i);
        bus.instr_rvalid_o = resp & (tail.host == HOST_INSTR);
        bus.data_rvalid_o  = resp & (tail.host == HOST_DATA);
        bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.ram_rdata_i : '0;
        bus.data_rdata_o   = bus.data_rvalid_o ? bus.ram_rdata_i : '0;
    end

    // Round-robin pointer and sticky protocol error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= HOST_DATA;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

    assign proto_err_o = err_q;

endmodule

// File: tb/tb_secure_ram_arbiter.sv
// tb_secure_ram_arbiter: vector table for request-side muxing plus scoreboard for routed responses
module tb_secure_ram_arbiter;
    import secure_ram_pkg::*;

    typedef struct {
        logic [2:0]  in_c;
        logic [31:0] ia;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ex_c;
        logic [3:0]  ebe;
        logic [31:0] eaddr;
        logic [31:0] ewd;
    } vec_t;

    typedef struct {
        logic        host;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        proto_err;
    logic        mon_en = 1'b0;
    logic [1:0]  rv_p = 2'b00;
    logic [31:0] rd_p0 = '0, rd_p1 = '0;
    logic        inject = 1'b0;
    logic [31:0] inject_data = '0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sbq[$];
    vec_t        t[18];

    always #5 clk = ~clk;

    secure_ram_arbiter_if #(.AW(32), .DW(32)) bus();

    secure_ram_arbiter #(.RAM_LATENCY(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .proto_err_o (proto_err)
    );

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    assign bus.ram_gnt_i    = bus.ram_req_o;
    assign bus.ram_rvalid_i = rv_p[1] | inject;
    assign bus.ram_rdata_i  = rv_p[1] ? rd_p1 : (inject ? inject_data : 32'h0);

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rv_p  <= {rv_p[0], bus.ram_req_o & bus.ram_gnt_i};
        rd_p0 <= bus.ram_we_o ? 32'h0 : ram_word(bus.ram_addr_o);
        rd_p1 <= rd_p0;
    end

    always @(negedge clk) begin
        exp_t e;
        #3;
        if (mon_en) begin
            chk("proto_err_clear", 32'(proto_err), 32'h0);
            if (!bus.instr_rvalid_o) chk("instr_rdata_zero", bus.instr_rdata_o, 32'h0);
            if (!bus.data_rvalid_o) chk("data_rdata_zero", bus.data_rdata_o, 32'h0);
            if (bus.instr_rvalid_o || bus.data_rvalid_o) begin
                chk("rvalid_onehot", 32'(bus.instr_rvalid_o & bus.data_rvalid_o), 32'h0);
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rvalid actual=1 required=0 cyc=%0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_host", 32'(bus.data_rvalid_o), 32'(e.host));
                    chk("resp_data", bus.data_rvalid_o ? bus.data_rdata_o : bus.instr_rdata_o, e.data);
                    chk("resp_cycle", cyc, e.cyc);
                end
            end
            if (bus.instr_gnt_o) sbq.push_back('{1'b0, ram_word(bus.instr_addr_i), cyc + 2});
            if (bus.data_gnt_o) sbq.push_back('{1'b1, bus.data_we_i ? 32'h0 : ram_word(bus.data_addr_i), cyc + 2});
        end
    end

    task automatic drive(input logic [2:0] c, input logic [31:0] ia, input logic [3:0] dbe,
                         input logic [31:0] da, input logic [31:0] dw);
        {bus.instr_req_i, bus.data_req_i, bus.data_we_i} = c;
        bus.instr_addr_i = ia;
        bus.data_be_i    = dbe;
        bus.data_addr_i  = da;
        bus.data_wdata_i = dw;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {instr_req,data_req,data_we}, ia, dbe, da, dw, {ig. dg, req, we}, be, addr, wdata
        t[0]  = '{3'b001, 32'h44, 4'h3, 32'h99, 32'hFFFF0000, 4'b0000, 4'h0, 32'h0,  32'h0};
        t[1]  = '{3'b110, 32'h0,  4'hF, 32'h4,  32'h0,        4'b1010, 4'hF, 32'h0,  32'h0};
        t[2]  = '{3'b110, 32'h0,  4'hF, 32'h4,  32'h0,        4'b0110, 4'hF, 32'h4,  32'h0};
        t[3]  = '{3'b110, 32'h0,  4'hF, 32'h4,  32'h0,        4'b1010, 4'hF, 32'h0,  32'h0};
        t[4]  = '{3'b110, 32'h0,  4'hF, 32'h4,  32'h0,        4'b0110, 4'hF, 32'h4,  32'h0};
        t[5]  = '{3'b000, 32'h0,  4'h0, 32'h0,  32'h0,        4'b0000, 4'h0, 32'h0,  32'h0};
        t[6]  = '{3'b000, 32'h0,  4'h0, 32'h0,  32'h0,        4'b0000, 4'h0, 32'h0,  32'h0};
        t[7]  = '{3'b101, 32'h10, 4'h3, 32'h77, 32'h1234,     4'b1010, 4'hF, 32'h10, 32'h0};
        t[8]  = '{3'b000, 32'h0,  4'h0, 32'h0,  32'h0,        4'b0000, 4'h0, 32'h0,  32'h0};
        t[9]  = '{3'b000, 32'h0,  4'h0, 32'h0,  32'h0,        4'b0000, 4'h0, 32'h0,  32'h0};
        t[10] = '{3'b011, 32'h0,  4'h3, 32'h20, 32'hDEADBEEF, 4'b0111, 4'h3, 32'h20, 32'hDEADBEEF};
        t[11] = '{3'b010, 32'h0,  4'hF, 32'h8,  32'h0,        4'b0110, 4'hF, 32'h8,  32'h0};
        t[12] = '{3'b110, 32'h14, 4'hF, 32'h18, 32'h0,        4'b1010, 4'hF, 32'h14, 32'h0};
        t[13] = '{3'b100, 32'h1C, 4'h0, 32'h0,  32'h0,        4'b1010, 4'hF, 32'h1C, 32'h0};
        t[14] = '{3'b110, 32'h14, 4'hF, 32'h18, 32'h0,        4'b0110, 4'hF, 32'h18, 32'h0};
        t[15] = '{3'b000, 32'h0,  4'h0, 32'h0,  32'h0,        4'b0000, 4'h0, 32'h0,  32'h0};
        t[16] = '{3'b000, 32'h0,  4'h0, 32'h0,  32'h0,        4'b0000, 4'h0, 32'h0,  32'h0};
        t[17] = '{3'b000, 32'h0,  4'h0, 32'h0,  32'h0,        4'b0000, 4'h0, 32'h0,  32'h0};

        drive(3'b000, 32'h0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #2;
        chk("rst_gnt_rvalid", 32'({bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o}), 32'h0);
        chk("rst_rdata", bus.instr_rdata_o | bus.data_rdata_o, 32'h0);
        chk("rst_proto_err", 32'(proto_err), 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(t[i].in_c, t[i].ia, t[i].dbe, t[i].da, t[i].dw);
            #2;
            chk($sformatf("v%0d_gnt", i), 32'({bus.instr_gnt_o, bus.data_gnt_o}), 32'(t[i].ex_c[3:2]));
            chk($sformatf("v%0d_req_we", i), 32'({bus.ram_req_o, bus.ram_we_o}), 32'(t[i].ex_c[1:0]));
            chk($sformatf("v%0d_be", i), 32'(bus.ram_be_o), 32'(t[i].ebe));
            chk($sformatf("v%0d_addr", i), bus.ram_addr_o, t[i].eaddr);
            chk($sformatf("v%0d_wdata", i), bus.ram_wdata_o, t[i].ewd);
        end
        repeat (3) @(negedge clk);
        #4;
        chk("sb_drained", sbq.size(), 32'h0);
        mon_en = 1'b0;

        @(negedge clk);
        inject      = 1'b1;
        inject_data = 32'hCAFEF00D;
        #2;
        chk("inj_no_rvalid", 32'({bus.instr_rvalid_o, bus.data_rvalid_o}), 32'h0);
        chk("inj_rdata_zero", bus.instr_rdata_o | bus.data_rdata_o, 32'h0);
        @(negedge clk);
        inject = 1'b0;
        #2;
        chk("inj_err_set", 32'(proto_err), 32'h1);
        repeat (2) @(negedge clk);
        #2;
        chk("inj_err_sticky", 32'(proto_err), 32'h1);
        rst_ni = 1'b0;
        #2;
        chk("inj_err_cleared", 32'(proto_err), 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;

        @(negedge clk);
        drive(3'b100, 32'h30, 4'h0, 32'h0, 32'h0);
        #2;
        chk("mid_gnt", 32'(bus.instr_gnt_o), 32'h1);
        @(negedge clk);
        drive(3'b000, 32'h0, 4'h0, 32'h0, 32'h0);
        rst_ni = 1'b0;
        #2;
        chk("mid_rst_outs", 32'({bus.ram_req_o, bus.instr_rvalid_o, bus.data_rvalid_o, proto_err}), 32'h0);
        chk("mid_rst_rdata", bus.instr_rdata_o | bus.data_rdata_o | bus.ram_addr_o, 32'h0);
        @(negedge clk);
        chk("mid_held_rvalid", 32'({bus.instr_rvalid_o, bus.data_rvalid_o}), 32'h0);
        rst_ni = 1'b1;
        #2;
        chk("mid_late_no_rvalid", 32'({bus.instr_rvalid_o, bus.data_rvalid_o}), 32'h0);
        chk("mid_late_rdata", bus.instr_rdata_o | bus.data_rdata_o, 32'h0);
        @(negedge clk);
        #2;
        chk("mid_late_err", 32'(proto_err), 32'h1);
        rst_ni = 1'b0;
        #2;
        chk("mid_err_cleared", 32'(proto_err), 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
